// File: rtl/gtfmac_link_bringup_ctrl_pkg.sv
// Shared types and constants for the GTF MAC link bring-up controller.
// Holds the state encoding, bus widths and the state -> control output decode.
package gtfmac_link_bringup_ctrl_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned RETRY_W = 4;
  localparam int unsigned DROP_W  = 16;
  localparam int unsigned LB_W    = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE         = 3'd0,
    ST_RST_ALL      = 3'd1,
    ST_WAIT_RSTDONE = 3'd2,
    ST_WAIT_LOCK    = 3'd3,
    ST_STABLE       = 3'd4,
    ST_UP           = 3'd5,
    ST_RX_RECOVER   = 3'd6,
    ST_FAIL         = 3'd7
  } state_e;

  // Per-state control outputs driven towards the MAC soft register wrapper.
  typedef struct packed {
    logic gt_reset_all;
    logic gt_rx_reset;
    logic tx_send_idle;
    logic tx_send_rfi;
    logic tx_send_lfi;
    logic link_up;
    logic link_fail;
  } ctl_out_t;

  // Control outputs while held in reset (same as the IDLE decode).
  localparam ctl_out_t CTL_RESET = '{
    gt_reset_all: 1'b1,
    gt_rx_reset:  1'b0,
    tx_send_idle: 1'b1,
    tx_send_rfi:  1'b0,
    tx_send_lfi:  1'b0,
    link_up:      1'b0,
    link_fail:    1'b0
  };

  // Moore decode of a state into its control outputs.
  function automatic ctl_out_t decode_state(input state_e st);
    ctl_out_t c;
    c = '0;
    unique case (st)
      ST_IDLE, ST_RST_ALL: begin
        c.gt_reset_all = 1'b1;
        c.tx_send_idle = 1'b1;
      end
      ST_WAIT_RSTDONE: c.tx_send_idle = 1'b1;
      ST_WAIT_LOCK, ST_STABLE: c.tx_send_rfi = 1'b1;
      ST_UP: c.link_up = 1'b1;
      ST_RX_RECOVER: begin
        c.gt_rx_reset = 1'b1;
        c.tx_send_lfi = 1'b1;
      end
      ST_FAIL: begin
        c.gt_reset_all = 1'b1;
        c.tx_send_idle = 1'b1;
        c.link_fail    = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/gtfmac_link_bringup_ctrl_timer.sv
// Dwell timer for the bring-up FSM: counts cycles spent in the current state.
// Ports: clk, rst (sync, active-high), clr (restart at 0), en (count),
//        cmp (terminal value), eq_c (combinational cnt == cmp).
module gtfmac_link_bringup_ctrl_timer #(
  parameter int unsigned CNT_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] cmp,
  output logic             eq_c
);

  logic [CNT_W-1:0] cnt_q;

  // Clear wins over count so a new state always starts from zero.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign eq_c = (cnt_q == cmp);

endmodule

// File: rtl/gtfmac_link_bringup_ctrl.sv
// GTF MAC link bring-up sequencer (s_axi_aclk domain).
// Sequences GT reset, reset-done wait, RX lock, stability qualification,
// link-up monitoring, RX-only recovery and bounded full-reset retries.
// Inputs : s_axi_aclk, s_axi_areset (sync, active-high), enable, start,
//          loopback_cfg, tx/rx_resetn_out_sync, stat_rx_status_sync,
//          stat_rx_hi_ber_sync (all pre-synchronized).
// Outputs: ctl_gt_* resets, ctl_local_loopback, ctl_tx_send_{idle,rfi,lfi},
//          link_up, link_fail, retry_cnt, link_drop_cnt, state_o; all registered.
module gtfmac_link_bringup_ctrl
  import gtfmac_link_bringup_ctrl_pkg::*;
#(
  parameter int unsigned RESET_PULSE_CYC = 16,
  parameter int unsigned TIMEOUT_CYC     = 1000000,
  parameter int unsigned STABLE_CYC      = 256,
  parameter int unsigned MAX_RETRIES     = 7,
  parameter int unsigned CNT_W           = 24
) (
  input  logic               s_axi_aclk,
  input  logic               s_axi_areset,
  input  logic               enable,
  input  logic               start,
  input  logic [LB_W-1:0]    loopback_cfg,
  input  logic               tx_resetn_out_sync,
  input  logic               rx_resetn_out_sync,
  input  logic               stat_rx_status_sync,
  input  logic               stat_rx_hi_ber_sync,
  output logic               ctl_gt_reset_all,
  output logic               ctl_gt_rx_reset,
  output logic               ctl_gt_tx_reset,
  output logic [LB_W-1:0]    ctl_local_loopback,
  output logic               ctl_tx_send_idle,
  output logic               ctl_tx_send_rfi,
  output logic               ctl_tx_send_lfi,
  output logic               link_up,
  output logic               link_fail,
  output logic [RETRY_W-1:0] retry_cnt,
  output logic [DROP_W-1:0]  link_drop_cnt,
  output logic [STATE_W-1:0] state_o
);

  localparam logic [CNT_W-1:0]   PULSE_LAST   = CNT_W'(RESET_PULSE_CYC - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(STABLE_CYC - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(MAX_RETRIES);
  localparam logic [DROP_W-1:0]  DROP_SAT     = '1;

  state_e             state_q, state_d;
  ctl_out_t           ctl_q;
  logic [RETRY_W-1:0] retry_cnt_q, retry_cnt_d;
  logic [DROP_W-1:0]  link_drop_cnt_q, link_drop_cnt_d;
  logic [LB_W-1:0]    loopback_q, loopback_d;

  logic               tmr_clr, tmr_en, tmr_eq_c;
  logic [CNT_W-1:0]   tmr_cmp;
  logic               link_good_c, resetn_done_c, retry_exhausted_c;

  assign link_good_c       = stat_rx_status_sync && !stat_rx_hi_ber_sync;
  assign resetn_done_c     = tx_resetn_out_sync && rx_resetn_out_sync;
  assign retry_exhausted_c = (retry_cnt_q == RETRY_MAX);

  // Single dwell timer; restarted on every state change. In STABLE it doubles
  // as the consecutive-good counter because any bad cycle leaves the state.
  assign tmr_clr = (state_d != state_q);

  gtfmac_link_bringup_ctrl_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk  (s_axi_aclk),
    .rst  (s_axi_areset),
    .clr  (tmr_clr),
    .en   (tmr_en),
    .cmp  (tmr_cmp),
    .eq_c (tmr_eq_c)
  );

  // Next-state, counter and timer-control logic.
  always_comb begin
    state_d         = state_q;
    retry_cnt_d     = retry_cnt_q;
    link_drop_cnt_d = link_drop_cnt_q;
    loopback_d      = loopback_q;
    tmr_en          = 1'b0;
    tmr_cmp         = TIMEOUT_LAST;

    unique case (state_q)
      ST_IDLE, ST_FAIL: begin
        if (start) begin
          state_d     = ST_RST_ALL;
          retry_cnt_d = '0;
          loopback_d  = loopback_cfg;
        end
      end
      ST_RST_ALL, ST_RX_RECOVER: begin
        tmr_en  = 1'b1;
        tmr_cmp = PULSE_LAST;
        if (tmr_eq_c) state_d = ST_WAIT_RSTDONE;
      end
      ST_WAIT_RSTDONE: begin
        tmr_en = 1'b1;
        if (resetn_done_c) begin
          state_d = ST_WAIT_LOCK;
        end else if (tmr_eq_c) begin
          if (retry_exhausted_c) begin
            state_d = ST_FAIL;
          end else begin
            state_d     = ST_RST_ALL;
            retry_cnt_d = retry_cnt_q + RETRY_W'(1);
          end
        end
      end
      ST_WAIT_LOCK: begin
        tmr_en = 1'b1;
        if (link_good_c) begin
          state_d = ST_STABLE;
        end else if (tmr_eq_c) begin
          if (retry_exhausted_c) begin
            state_d = ST_FAIL;
          end else begin
            state_d     = ST_RST_ALL;
            retry_cnt_d = retry_cnt_q + RETRY_W'(1);
          end
        end
      end
      ST_STABLE: begin
        tmr_en  = 1'b1;
        tmr_cmp = STABLE_LAST;
        if (!link_good_c) begin
          state_d = ST_WAIT_LOCK;
        end else if (tmr_eq_c) begin
          state_d = ST_UP;
        end
      end
      ST_UP: begin
        // RX-only recovery: retry budget is deliberately left alone here.
        if (!link_good_c) begin
          state_d = ST_RX_RECOVER;
          if (link_drop_cnt_q != DROP_SAT) begin
            link_drop_cnt_d = link_drop_cnt_q + DROP_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Disable overrides everything, including a coincident start.
    if (!enable) begin
      state_d         = ST_IDLE;
      retry_cnt_d     = retry_cnt_q;
      link_drop_cnt_d = link_drop_cnt_q;
      loopback_d      = loopback_q;
    end
  end

  // State, counters and registered output decode of the next state.
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      state_q         <= ST_IDLE;
      ctl_q           <= CTL_RESET;
      retry_cnt_q     <= '0;
      link_drop_cnt_q <= '0;
      loopback_q      <= '0;
    end else begin
      state_q         <= state_d;
      ctl_q           <= decode_state(state_d);
      retry_cnt_q     <= retry_cnt_d;
      link_drop_cnt_q <= link_drop_cnt_d;
      loopback_q      <= loopback_d;
    end
  end

  assign ctl_gt_reset_all   = ctl_q.gt_reset_all;
  assign ctl_gt_rx_reset    = ctl_q.gt_rx_reset;
  assign ctl_gt_tx_reset    = 1'b0;
  assign ctl_local_loopback = loopback_q;
  assign ctl_tx_send_idle   = ctl_q.tx_send_idle;
  assign ctl_tx_send_rfi    = ctl_q.tx_send_rfi;
  assign ctl_tx_send_lfi    = ctl_q.tx_send_lfi;
  assign link_up            = ctl_q.link_up;
  assign link_fail          = ctl_q.link_fail;
  assign retry_cnt          = retry_cnt_q;
  assign link_drop_cnt      = link_drop_cnt_q;
  assign state_o            = state_q;

endmodule

// File: tb/tb_gtfmac_link_bringup_ctrl.sv
// Bench for gtfmac_link_bringup_ctrl: directed scenarios with randomized timing
// plus a random soak. A cycle-level behavioural model pushes every expected
// change of the DUT output vector (with its cycle stamp) into a queue; a
// negedge monitor pops and compares whenever the DUT outputs change.
module tb_gtfmac_link_bringup_ctrl;

  localparam int P  = 4;
  localparam int TO = 64;
  localparam int SC = 8;
  localparam int MR = 2;
  localparam int CW = 16;

  localparam int S_IDLE = 0, S_RST_ALL = 1, S_WAIT_RSTDONE = 2, S_WAIT_LOCK = 3;
  localparam int S_STABLE = 4, S_UP = 5, S_RX_RECOVER = 6, S_FAIL = 7;

  logic        clk = 1'b0;
  logic        s_axi_areset = 1'b1;
  logic        enable = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  loopback_cfg = 3'b000;
  logic        tx = 1'b0, rx = 1'b0, stat = 1'b0, hb = 1'b0;
  logic        ctl_gt_reset_all, ctl_gt_rx_reset, ctl_gt_tx_reset;
  logic [2:0]  ctl_local_loopback;
  logic        ctl_tx_send_idle, ctl_tx_send_rfi, ctl_tx_send_lfi;
  logic        link_up, link_fail;
  logic [3:0]  retry_cnt;
  logic [15:0] link_drop_cnt;
  logic [2:0]  state_o;

  gtfmac_link_bringup_ctrl #(
    .RESET_PULSE_CYC (P),
    .TIMEOUT_CYC     (TO),
    .STABLE_CYC      (SC),
    .MAX_RETRIES     (MR),
    .CNT_W           (CW)
  ) dut (
    .s_axi_aclk          (clk),
    .s_axi_areset        (s_axi_areset),
    .enable              (enable),
    .start               (start),
    .loopback_cfg        (loopback_cfg),
    .tx_resetn_out_sync  (tx),
    .rx_resetn_out_sync  (rx),
    .stat_rx_status_sync (stat),
    .stat_rx_hi_ber_sync (hb),
    .ctl_gt_reset_all    (ctl_gt_reset_all),
    .ctl_gt_rx_reset     (ctl_gt_rx_reset),
    .ctl_gt_tx_reset     (ctl_gt_tx_reset),
    .ctl_local_loopback  (ctl_local_loopback),
    .ctl_tx_send_idle    (ctl_tx_send_idle),
    .ctl_tx_send_rfi     (ctl_tx_send_rfi),
    .ctl_tx_send_lfi     (ctl_tx_send_lfi),
    .link_up             (link_up),
    .link_fail           (link_fail),
    .retry_cnt           (retry_cnt),
    .link_drop_cnt       (link_drop_cnt),
    .state_o             (state_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          cyc;
    logic [33:0] snap;
  } ev_t;
  ev_t exp_q[$];

  // Output vector: state, reset_all, rx_reset, tx_reset, loopback, idle, rfi,
  // lfi, link_up, link_fail, retry_cnt, link_drop_cnt.
  function automatic logic [33:0] mk_snap(input int st, input logic [3:0] r,
                                          input logic [15:0] d, input logic [2:0] lb);
    logic ra, rr, idl, rfi, lfi, up, fl;
    ra  = (st == S_IDLE) || (st == S_RST_ALL) || (st == S_FAIL);
    rr  = (st == S_RX_RECOVER);
    idl = (st == S_IDLE) || (st == S_RST_ALL) || (st == S_WAIT_RSTDONE) || (st == S_FAIL);
    rfi = (st == S_WAIT_LOCK) || (st == S_STABLE);
    lfi = (st == S_RX_RECOVER);
    up  = (st == S_UP);
    fl  = (st == S_FAIL);
    return {3'(st), ra, rr, 1'b0, lb, idl, rfi, lfi, up, fl, r, d};
  endfunction

  function automatic logic [33:0] dut_snap();
    return {state_o, ctl_gt_reset_all, ctl_gt_rx_reset, ctl_gt_tx_reset, ctl_local_loopback,
            ctl_tx_send_idle, ctl_tx_send_rfi, ctl_tx_send_lfi, link_up, link_fail,
            retry_cnt, link_drop_cnt};
  endfunction

  // ---------------- behavioural model ----------------
  int          m_state = S_IDLE;
  int          m_dwell = 0;     // cycles already completed in m_state
  logic [3:0]  m_retry = '0;
  logic [15:0] m_drop  = '0;
  logic [2:0]  m_lb    = '0;
  logic [33:0] m_prev  = '0;

  task automatic emit(input int stamp);
    logic [33:0] s;
    ev_t e;
    s = mk_snap(m_state, m_retry, m_drop, m_lb);
    if (s != m_prev) begin
      e.cyc  = stamp;
      e.snap = s;
      exp_q.push_back(e);
    end
    m_prev = s;
  endtask

  task automatic model_retry(output int nxt);
    if (int'(m_retry) == MR) begin
      nxt = S_FAIL;
    end else begin
      m_retry = m_retry + 4'd1;
      nxt = S_RST_ALL;
    end
  endtask

  // Applies the rules to the inputs present now; result is visible after the next edge.
  task automatic model_step();
    int nxt;
    logic good;
    good = stat && !hb;
    nxt  = m_state;
    if (s_axi_areset) begin
      nxt = S_IDLE; m_retry = '0; m_drop = '0; m_lb = '0;
    end else if (!enable) begin
      nxt = S_IDLE;
    end else begin
      case (m_state)
        S_IDLE, S_FAIL:
          if (start) begin nxt = S_RST_ALL; m_lb = loopback_cfg; m_retry = '0; end
        S_RST_ALL, S_RX_RECOVER:
          if (m_dwell + 1 == P) nxt = S_WAIT_RSTDONE;
        S_WAIT_RSTDONE:
          if (tx && rx) nxt = S_WAIT_LOCK;
          else if (m_dwell + 1 == TO) model_retry(nxt);
        S_WAIT_LOCK:
          if (good) nxt = S_STABLE;
          else if (m_dwell + 1 == TO) model_retry(nxt);
        S_STABLE:
          if (!good) nxt = S_WAIT_LOCK;
          else if (m_dwell + 1 == SC) nxt = S_UP;
        S_UP:
          if (!good) begin
            nxt = S_RX_RECOVER;
            if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
          end
        default: ;
      endcase
    end
    if (nxt != m_state || s_axi_areset) m_dwell = 0;
    else m_dwell = m_dwell + 1;
    m_state = nxt;
    emit(cyc + 1);
  endtask

  // ---------------- monitor ----------------
  logic        mon_on = 1'b0;
  logic [33:0] mon_prev = '0;
  logic [33:0] mon_cur;
  ev_t         mon_e;

  always @(negedge clk) begin
    if (mon_on) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        mon_e = exp_q.pop_front();
        checks++;
        errors++;
        $display("FAIL missing_change exp_cyc=%0d exp=%h got=%h", mon_e.cyc, mon_e.snap, dut_snap());
      end
      mon_cur = dut_snap();
      if (mon_cur != mon_prev) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change cyc=%0d got=%h required=no change from %h",
                   cyc, mon_cur, mon_prev);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_e.cyc != cyc || mon_e.snap != mon_cur) begin
            errors++;
            $display("FAIL output_change cyc=%0d got=%h required=%h at cyc %0d",
                     cyc, mon_cur, mon_e.snap, mon_e.cyc);
          end
        end
        mon_prev = mon_cur;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic pulse_start(input logic [2:0] lb);
    loopback_cfg = lb;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_until(input int st, input int limit);
    int k;
    k = 0;
    while (m_state != st && k < limit) begin
      tick();
      k++;
    end
    if (m_state != st) begin
      checks++;
      errors++;
      $display("FAIL run_until_timeout got_state=%0d required_state=%0d", m_state, st);
    end
  endtask

  task automatic link_drop_and_relink();
    hb = 1'b1;
    tick();
    hb = 1'b0;
    run_until(S_UP, 200);
    run(2);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d required=finish before watchdog", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    m_prev = mk_snap(S_IDLE, '0, '0, '0);
    @(posedge clk);
    #1;
    run(3);
    s_axi_areset = 1'b0;

    // Reset values.
    checks++;
    if (dut_snap() != mk_snap(S_IDLE, '0, '0, '0)) begin
      errors++;
      $display("FAIL reset_state got=%h required=%h", dut_snap(), mk_snap(S_IDLE, '0, '0, '0));
    end
    mon_prev = mk_snap(S_IDLE, '0, '0, '0);
    mon_on   = 1'b1;
    run(2);

    // Nominal bring-up; loopback changes while busy must not be picked up.
    pulse_start(3'b010);
    loopback_cfg = 3'b000;
    run(9);
    tx = 1'b1; rx = 1'b1;
    run(9);
    stat = 1'b1;
    run_until(S_UP, 50);
    run(3 + $urandom_range(0, 5));

    // One-cycle hi_ber in UP: RX-only recovery then relink.
    link_drop_and_relink();

    // Lock flap at good-count 5 in STABLE.
    hb = 1'b1;
    tick();
    hb = 1'b0;
    run_until(S_STABLE, 50);
    run(5);
    stat = 1'b0;
    tick();
    stat = 1'b1;
    run(int'($urandom_range(0, 3)));
    run_until(S_UP, 100);
    run(2);

    // Drop counter saturation: preload near the top, then drop repeatedly.
    force dut.link_drop_cnt_q = 16'hFFFD;
    m_drop = 16'hFFFD;
    emit(cyc);
    tick();
    release dut.link_drop_cnt_q;
    run(2);
    repeat (3) link_drop_and_relink();

    // start while busy is ignored; then disable with start in WAIT_LOCK.
    pulse_start(3'b111);
    run(2);
    stat = 1'b0;
    run_until(S_WAIT_LOCK, 30);
    run(3);
    enable = 1'b0;
    start  = 1'b1;
    loopback_cfg = 3'b101;
    tick();
    enable = 1'b1;
    start  = 1'b0;
    run(3);

    // Exhaust retries via lock timeouts, then restart from FAIL.
    pulse_start(3'($urandom_range(0, 7)));
    run_until(S_FAIL, 400);
    run(3);
    tx = 1'b0; rx = 1'b0;
    pulse_start(3'($urandom_range(0, 7)));
    // Exhaust retries via reset-done timeouts.
    run_until(S_FAIL, 400);
    run(2);

    // Reset mid-sequence.
    pulse_start(3'b011);
    run(2 + $urandom_range(0, 3));
    s_axi_areset = 1'b1;
    tick();
    s_axi_areset = 1'b0;
    run(3);

    // Random soak.
    tx = 1'b1; rx = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      s_axi_areset = ($urandom_range(0, 499) == 0);
      enable       = ($urandom_range(0, 149) != 0);
      start        = ($urandom_range(0, 19) == 0);
      loopback_cfg = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 29) == 0) tx = ~tx;
      if ($urandom_range(0, 29) == 0) rx = ~rx;
      stat = ($urandom_range(0, 15) != 0);
      hb   = ($urandom_range(0, 49) == 0);
      tick();
    end
    s_axi_areset = 1'b0;
    enable = 1'b1;
    start  = 1'b0;
    hb     = 1'b0;
    run(5);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_changes got=%0d required=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
